// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU instruction at a time. It drives the function
// code and the result enable for a fixed settle window, then pulses the load
// of register A or D and captures the condition codes from the ALU outputs.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_carry_i,
  input  logic       alu_zero_i,
  output logic [2:0] fctn_code_o,
  output logic       alu_enable_o,
  output logic       load_a_o,
  output logic       load_d_o,
  output logic       cc_sign_o,
  output logic       cc_carry_o,
  output logic       cc_zero_o,
  output logic       done_o,
  output logic       illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_LATCH  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] ALU_CLASS = 4'b1000;
  localparam logic [2:0] FN_ADD    = 3'd0;
  localparam logic [2:0] FN_INC    = 3'd1;
  // Counter starts one below the settle length so SETTLE lasts exactly
  // SETTLE_CYCLES cycles, including the cycle in which it reads zero.
  localparam logic [3:0] CNT_INIT  = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fctn_q, fctn_d;
  logic       dest_q, dest_d;
  logic       illegal_q, illegal_d;
  logic       alu_enable_q, alu_enable_d;
  logic       load_a_q, load_a_d;
  logic       load_d_q, load_d_d;
  logic       done_q, done_d;
  logic       cc_sign_q, cc_sign_d;
  logic       cc_carry_q, cc_carry_d;
  logic       cc_zero_q, cc_zero_d;
  logic       accept_s;

  // Ready is combinational from state so it rises as soon as reset releases.
  assign instr_ready_o = rst_n & (state_q == S_IDLE);
  assign accept_s      = instr_valid_i & (state_q == S_IDLE);

  // Next-state logic: FSM sequencing, instruction capture and strobe decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fctn_d       = fctn_q;
    dest_d       = dest_q;
    illegal_d    = 1'b0;
    cc_sign_d    = cc_sign_q;
    cc_carry_d   = cc_carry_q;
    cc_zero_d    = cc_zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (instr_i[7:4] == ALU_CLASS) begin
            fctn_d  = instr_i[2:0];
            dest_d  = instr_i[3];
            cnt_d   = CNT_INIT;
            state_d = S_SETTLE;
          end else begin
            illegal_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LATCH: begin
        // Condition codes sample the settled ALU outputs at the end of LATCH;
        // carry is only meaningful for the adder functions.
        cc_zero_d = alu_zero_i;
        cc_sign_d = alu_result_i[7];
        if ((fctn_q == FN_ADD) || (fctn_q == FN_INC)) begin
          cc_carry_d = alu_carry_i;
        end else begin
          cc_carry_d = cc_carry_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they leave flops directly.
    alu_enable_d = (state_d == S_SETTLE) || (state_d == S_LATCH);
    load_a_d     = (state_d == S_LATCH) & ~dest_d;
    load_d_d     = (state_d == S_LATCH) &  dest_d;
    done_d       = (state_d == S_DONE);
  end

  // State, datapath and registered-output flops; reset abandons any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      fctn_q       <= 3'd0;
      dest_q       <= 1'b0;
      illegal_q    <= 1'b0;
      alu_enable_q <= 1'b0;
      load_a_q     <= 1'b0;
      load_d_q     <= 1'b0;
      done_q       <= 1'b0;
      cc_sign_q    <= 1'b0;
      cc_carry_q   <= 1'b0;
      cc_zero_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fctn_q       <= fctn_d;
      dest_q       <= dest_d;
      illegal_q    <= illegal_d;
      alu_enable_q <= alu_enable_d;
      load_a_q     <= load_a_d;
      load_d_q     <= load_d_d;
      done_q       <= done_d;
      cc_sign_q    <= cc_sign_d;
      cc_carry_q   <= cc_carry_d;
      cc_zero_q    <= cc_zero_d;
    end
  end

  assign fctn_code_o  = fctn_q;
  assign alu_enable_o = alu_enable_q;
  assign load_a_o     = load_a_q;
  assign load_d_o     = load_d_q;
  assign done_o       = done_q;
  assign illegal_o    = illegal_q;
  assign cc_sign_o    = cc_sign_q;
  assign cc_carry_o   = cc_carry_q;
  assign cc_zero_o    = cc_zero_q;

endmodule
